// File: rtl/ctrl_pipe.sv
// ctrl_pipe: carries the decoded control bundle through the ID/EX, EX/MEM and
// MEM/WB pipeline registers. It resolves branches and jumps in EX against the
// static fetch-time prediction, drives the PC redirect and the IF/ID and ID/EX
// flushes, and keeps saturating branch and mispredict counters.
module ctrl_pipe #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ValidD,
  input  logic             RegWriteD,
  input  logic [1:0]       ResultSrcD,
  input  logic             MemWriteD,
  input  logic             JumpD,
  input  logic             BranchD,
  input  logic             ALUSrcD,
  input  logic [2:0]       ALUControlD,
  input  logic             funct3b0D,
  input  logic             PredTakenD,
  input  logic             FlushEExt,
  input  logic             ZeroE,
  output logic             ALUSrcE,
  output logic [2:0]       ALUControlE,
  output logic             MemWriteM,
  output logic             RegWriteM,
  output logic [1:0]       ResultSrcW,
  output logic             RegWriteW,
  output logic             RedirectE,
  output logic             RedirectSelE,
  output logic             FlushD,
  output logic             FlushE,
  output logic [CNT_W-1:0] BranchCnt,
  output logic [CNT_W-1:0] MispredCnt
);

  // ID/EX register
  logic       valid_e_q, valid_e_d;
  logic       reg_write_e_q, reg_write_e_d;
  logic [1:0] result_src_e_q, result_src_e_d;
  logic       mem_write_e_q, mem_write_e_d;
  logic       jump_e_q, jump_e_d;
  logic       branch_e_q, branch_e_d;
  logic       alu_src_e_q, alu_src_e_d;
  logic [2:0] alu_control_e_q, alu_control_e_d;
  logic       funct3b0_e_q, funct3b0_e_d;
  logic       pred_taken_e_q, pred_taken_e_d;

  // EX/MEM register
  logic       valid_m_q;
  logic       reg_write_m_q;
  logic [1:0] result_src_m_q;
  logic       mem_write_m_q;

  // MEM/WB register
  logic       valid_w_q;
  logic       reg_write_w_q;
  logic [1:0] result_src_w_q;

  // Performance counters
  logic [CNT_W-1:0] branch_cnt_q, branch_cnt_d;
  logic [CNT_W-1:0] mispred_cnt_q, mispred_cnt_d;

  // EX resolution
  logic taken_e_s;
  logic ctrl_e_s;
  logic redirect_e_s;
  logic flush_e_s;

  // Branch/jump resolution in EX; redirect and flushes are held low in reset.
  always_comb begin
    taken_e_s    = valid_e_q & (jump_e_q | (branch_e_q & (ZeroE ^ funct3b0_e_q)));
    ctrl_e_s     = valid_e_q & (jump_e_q | branch_e_q);
    redirect_e_s = ~reset & ctrl_e_s & (taken_e_s != pred_taken_e_q);
    flush_e_s    = redirect_e_s | (FlushEExt & ~reset);
  end

  // ID/EX next state: a flush or an invalid ID instruction loads a bubble.
  always_comb begin
    valid_e_d       = 1'b0;
    reg_write_e_d   = 1'b0;
    result_src_e_d  = 2'b00;
    mem_write_e_d   = 1'b0;
    jump_e_d        = 1'b0;
    branch_e_d      = 1'b0;
    alu_src_e_d     = 1'b0;
    alu_control_e_d = 3'b000;
    funct3b0_e_d    = 1'b0;
    pred_taken_e_d  = 1'b0;
    if (ValidD && !flush_e_s) begin
      valid_e_d       = 1'b1;
      reg_write_e_d   = RegWriteD;
      result_src_e_d  = ResultSrcD;
      mem_write_e_d   = MemWriteD;
      jump_e_d        = JumpD;
      branch_e_d      = BranchD;
      alu_src_e_d     = ALUSrcD;
      alu_control_e_d = ALUControlD;
      funct3b0_e_d    = funct3b0D;
      pred_taken_e_d  = PredTakenD;
    end else begin
      valid_e_d = 1'b0;
    end
  end

  // Saturating counter next state; they stop at all-ones instead of wrapping.
  always_comb begin
    branch_cnt_d  = branch_cnt_q;
    mispred_cnt_d = mispred_cnt_q;
    if (ctrl_e_s && (branch_cnt_q != {CNT_W{1'b1}})) begin
      branch_cnt_d = branch_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      branch_cnt_d = branch_cnt_q;
    end
    if (redirect_e_s && (mispred_cnt_q != {CNT_W{1'b1}})) begin
      mispred_cnt_d = mispred_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      mispred_cnt_d = mispred_cnt_q;
    end
  end

  // Pipeline registers and counters; synchronous reset discards all in-flight control.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_e_q       <= 1'b0;
      reg_write_e_q   <= 1'b0;
      result_src_e_q  <= 2'b00;
      mem_write_e_q   <= 1'b0;
      jump_e_q        <= 1'b0;
      branch_e_q      <= 1'b0;
      alu_src_e_q     <= 1'b0;
      alu_control_e_q <= 3'b000;
      funct3b0_e_q    <= 1'b0;
      pred_taken_e_q  <= 1'b0;
      valid_m_q       <= 1'b0;
      reg_write_m_q   <= 1'b0;
      result_src_m_q  <= 2'b00;
      mem_write_m_q   <= 1'b0;
      valid_w_q       <= 1'b0;
      reg_write_w_q   <= 1'b0;
      result_src_w_q  <= 2'b00;
      branch_cnt_q    <= {CNT_W{1'b0}};
      mispred_cnt_q   <= {CNT_W{1'b0}};
    end else begin
      valid_e_q       <= valid_e_d;
      reg_write_e_q   <= reg_write_e_d;
      result_src_e_q  <= result_src_e_d;
      mem_write_e_q   <= mem_write_e_d;
      jump_e_q        <= jump_e_d;
      branch_e_q      <= branch_e_d;
      alu_src_e_q     <= alu_src_e_d;
      alu_control_e_q <= alu_control_e_d;
      funct3b0_e_q    <= funct3b0_e_d;
      pred_taken_e_q  <= pred_taken_e_d;
      // The resolving instruction itself keeps flowing into MEM.
      valid_m_q       <= valid_e_q;
      reg_write_m_q   <= reg_write_e_q;
      result_src_m_q  <= result_src_e_q;
      mem_write_m_q   <= mem_write_e_q;
      valid_w_q       <= valid_m_q;
      reg_write_w_q   <= reg_write_m_q;
      result_src_w_q  <= result_src_m_q;
      branch_cnt_q    <= branch_cnt_d;
      mispred_cnt_q   <= mispred_cnt_d;
    end
  end

  assign ALUSrcE      = alu_src_e_q;
  assign ALUControlE  = alu_control_e_q;
  assign MemWriteM    = mem_write_m_q;
  assign RegWriteM    = reg_write_m_q;
  assign ResultSrcW   = result_src_w_q;
  assign RegWriteW    = reg_write_w_q;
  assign RedirectE    = redirect_e_s;
  assign RedirectSelE = pred_taken_e_q & ~taken_e_s;
  assign FlushD       = redirect_e_s;
  assign FlushE       = flush_e_s;
  assign BranchCnt    = branch_cnt_q;
  assign MispredCnt   = mispred_cnt_q;

endmodule

// File: tb/tb_ctrl_pipe.sv
// Directed table-driven bench for ctrl_pipe: a 32-bit-counter instance and a
// 4-bit-counter instance share all stimulus; the narrow one shows saturation.
module tb_ctrl_pipe;

  // ID bundle: v, rw, rs[1:0], mw, j, b, as, ac[2:0], f3b0, pred
  typedef logic [13:0] id_t;

  // Expected ctl: as_e, ac_e[2:0], mw_m, rw_m, rs_w[1:0], rw_w, redir, rsel, flushD, flushE
  typedef struct {
    logic        rst;
    id_t         id;
    logic        fx;
    logic        z;
    logic [12:0] exp_ctl;
    int          bc;
    int          mc;
  } vec_t;

  logic clk;
  logic reset;
  logic ValidD, RegWriteD, MemWriteD, JumpD, BranchD, ALUSrcD, funct3b0D, PredTakenD;
  logic [1:0] ResultSrcD;
  logic [2:0] ALUControlD;
  logic FlushEExt, ZeroE;

  logic        ALUSrcE, MemWriteM, RegWriteM, RegWriteW, RedirectE, RedirectSelE, FlushD, FlushE;
  logic [2:0]  ALUControlE;
  logic [1:0]  ResultSrcW;
  logic [31:0] BranchCnt, MispredCnt;

  logic        ALUSrcE4, MemWriteM4, RegWriteM4, RegWriteW4, RedirectE4, RedirectSelE4, FlushD4, FlushE4;
  logic [2:0]  ALUControlE4;
  logic [1:0]  ResultSrcW4;
  logic [3:0]  BranchCnt4, MispredCnt4;

  int pass_cnt = 0;
  int total_cnt = 0;
  vec_t vecs[$];

  ctrl_pipe #(.CNT_W(32)) dut (
    .clk(clk), .reset(reset), .ValidD(ValidD), .RegWriteD(RegWriteD), .ResultSrcD(ResultSrcD),
    .MemWriteD(MemWriteD), .JumpD(JumpD), .BranchD(BranchD), .ALUSrcD(ALUSrcD),
    .ALUControlD(ALUControlD), .funct3b0D(funct3b0D), .PredTakenD(PredTakenD),
    .FlushEExt(FlushEExt), .ZeroE(ZeroE), .ALUSrcE(ALUSrcE), .ALUControlE(ALUControlE),
    .MemWriteM(MemWriteM), .RegWriteM(RegWriteM), .ResultSrcW(ResultSrcW), .RegWriteW(RegWriteW),
    .RedirectE(RedirectE), .RedirectSelE(RedirectSelE), .FlushD(FlushD), .FlushE(FlushE),
    .BranchCnt(BranchCnt), .MispredCnt(MispredCnt)
  );

  ctrl_pipe #(.CNT_W(4)) dut4 (
    .clk(clk), .reset(reset), .ValidD(ValidD), .RegWriteD(RegWriteD), .ResultSrcD(ResultSrcD),
    .MemWriteD(MemWriteD), .JumpD(JumpD), .BranchD(BranchD), .ALUSrcD(ALUSrcD),
    .ALUControlD(ALUControlD), .funct3b0D(funct3b0D), .PredTakenD(PredTakenD),
    .FlushEExt(FlushEExt), .ZeroE(ZeroE), .ALUSrcE(ALUSrcE4), .ALUControlE(ALUControlE4),
    .MemWriteM(MemWriteM4), .RegWriteM(RegWriteM4), .ResultSrcW(ResultSrcW4), .RegWriteW(RegWriteW4),
    .RedirectE(RedirectE4), .RedirectSelE(RedirectSelE4), .FlushD(FlushD4), .FlushE(FlushE4),
    .BranchCnt(BranchCnt4), .MispredCnt(MispredCnt4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam id_t NOP  = 14'b0_0_00_0_0_0_0_000_0_0;
  localparam id_t ADDI = 14'b1_1_00_0_0_0_1_000_0_0;
  localparam id_t LW   = 14'b1_1_01_0_0_0_1_000_0_0;
  localparam id_t SUB  = 14'b1_1_00_0_0_0_0_001_0_0;
  localparam id_t SW   = 14'b1_0_00_1_0_0_1_000_0_0;
  localparam id_t BEQ0 = 14'b1_0_00_0_0_1_0_001_0_0;
  localparam id_t BNE1 = 14'b1_0_00_0_0_1_0_001_1_1;
  localparam id_t JAL0 = 14'b1_1_10_0_1_0_0_000_0_0;
  localparam id_t JAL1 = 14'b1_1_10_0_1_0_0_000_0_1;
  localparam id_t JUNK = 14'b0_1_01_1_0_1_1_111_0_1;

  task automatic add(input logic rst, input id_t id, input logic fx, input logic z,
                     input logic [12:0] exp_ctl, input int bc, input int mc);
    vec_t v;
    v.rst = rst; v.id = id; v.fx = fx; v.z = z; v.exp_ctl = exp_ctl; v.bc = bc; v.mc = mc;
    vecs.push_back(v);
  endtask

  task automatic drive(input logic rst, input id_t id, input logic fx, input logic z);
    reset = rst;
    {ValidD, RegWriteD, ResultSrcD, MemWriteD, JumpD, BranchD, ALUSrcD, ALUControlD,
     funct3b0D, PredTakenD} = id;
    FlushEExt = fx;
    ZeroE = z;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [12:0] act_ctl();
    return {ALUSrcE, ALUControlE, MemWriteM, RegWriteM, ResultSrcW, RegWriteW,
            RedirectE, RedirectSelE, FlushD, FlushE};
  endfunction

  function automatic int sat4(input int n);
    return (n > 15) ? 15 : n;
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    //   rst   id    fx    z     as_ac_mw_rw_rs_rw_rd_sel_fd_fe      bc mc
    add(1'b1, NOP,  1'b0, 1'b0, 13'b0_000_0_0_00_0_0_0_0_0,  0, 0);
    add(1'b0, ADDI, 1'b0, 1'b0, 13'b0_000_0_0_00_0_0_0_0_0,  0, 0);
    add(1'b0, LW,   1'b0, 1'b0, 13'b1_000_0_0_00_0_0_0_0_0,  0, 0);
    add(1'b0, SUB,  1'b0, 1'b0, 13'b1_000_0_1_00_0_0_0_0_0,  0, 0);
    add(1'b0, SW,   1'b0, 1'b0, 13'b0_001_0_1_00_1_0_0_0_0,  0, 0);
    add(1'b0, NOP,  1'b0, 1'b0, 13'b1_000_0_1_01_1_0_0_0_0,  0, 0);
    add(1'b0, NOP,  1'b0, 1'b0, 13'b0_000_1_0_00_1_0_0_0_0,  0, 0);
    // beq predicted not-taken, resolves taken: redirect and flush the ADDI behind it
    add(1'b0, BEQ0, 1'b0, 1'b0, 13'b0_000_0_0_00_0_0_0_0_0,  0, 0);
    add(1'b0, ADDI, 1'b0, 1'b1, 13'b0_001_0_0_00_0_1_0_1_1,  0, 0);
    add(1'b0, NOP,  1'b0, 1'b0, 13'b0_000_0_0_00_0_0_0_0_0,  1, 1);
    // bne predicted taken: Zero=1 -> not taken (redirect to PC+4), Zero=0 -> correct
    add(1'b0, BNE1, 1'b0, 1'b0, 13'b0_000_0_0_00_0_0_0_0_0,  1, 1);
    add(1'b0, NOP,  1'b0, 1'b1, 13'b0_001_0_0_00_0_1_1_1_1,  1, 1);
    add(1'b0, BNE1, 1'b0, 1'b0, 13'b0_000_0_0_00_0_0_0_0_0,  2, 2);
    add(1'b0, NOP,  1'b0, 1'b0, 13'b0_001_0_0_00_0_0_0_0_0,  2, 2);
    // jumps predicted not-taken then taken
    add(1'b0, JAL0, 1'b0, 1'b0, 13'b0_000_0_0_00_0_0_0_0_0,  3, 2);
    add(1'b0, NOP,  1'b0, 1'b0, 13'b0_000_0_0_00_0_1_0_1_1,  3, 2);
    add(1'b0, JAL1, 1'b0, 1'b0, 13'b0_000_0_1_00_0_0_0_0_0,  4, 3);
    add(1'b0, NOP,  1'b0, 1'b0, 13'b0_000_0_0_10_1_0_0_0_0,  4, 3);
    // external flush coinciding with a mispredict
    add(1'b0, BEQ0, 1'b0, 1'b0, 13'b0_000_0_1_00_0_0_0_0_0,  5, 3);
    add(1'b0, ADDI, 1'b1, 1'b1, 13'b0_001_0_0_10_1_1_0_1_1,  5, 3);
    add(1'b0, NOP,  1'b0, 1'b0, 13'b0_000_0_0_00_0_0_0_0_0,  6, 4);
    // external flush over a branch in ID: it never resolves
    add(1'b0, BEQ0, 1'b1, 1'b0, 13'b0_000_0_0_00_0_0_0_0_1,  6, 4);
    add(1'b0, NOP,  1'b0, 1'b1, 13'b0_000_0_0_00_0_0_0_0_0,  6, 4);
    // invalid ID instruction with live-looking fields is a bubble
    add(1'b0, JUNK, 1'b0, 1'b0, 13'b0_000_0_0_00_0_0_0_0_0,  6, 4);
    add(1'b0, NOP,  1'b0, 1'b0, 13'b0_000_0_0_00_0_0_0_0_0,  6, 4);
    // reset while a mispredicting beq sits in EX
    add(1'b0, BEQ0, 1'b0, 1'b0, 13'b0_000_0_0_00_0_0_0_0_0,  6, 4);
    add(1'b1, NOP,  1'b1, 1'b1, 13'b0_001_0_0_00_0_0_0_0_0,  6, 4);
    add(1'b0, NOP,  1'b0, 1'b0, 13'b0_000_0_0_00_0_0_0_0_0,  0, 0);

    drive(1'b1, NOP, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].rst, vecs[i].id, vecs[i].fx, vecs[i].z);
      #2;
      check($sformatf("row%0d ctl", i), 64'(act_ctl()), 64'(vecs[i].exp_ctl));
      check($sformatf("row%0d cnt32", i), {BranchCnt, MispredCnt},
            {32'(vecs[i].bc), 32'(vecs[i].mc)});
      check($sformatf("row%0d cnt4", i), 64'({BranchCnt4, MispredCnt4}),
            64'({4'(sat4(vecs[i].bc)), 4'(sat4(vecs[i].mc))}));
      next_cycle();
    end

    // Saturation: 20 mispredicting beqs, one every other cycle.
    drive(1'b1, NOP, 1'b0, 1'b0);
    next_cycle();
    for (int n = 0; n < 20; n++) begin
      drive(1'b0, BEQ0, 1'b0, 1'b0);
      #2;
      check($sformatf("sat%0d cnt4", n), 64'({BranchCnt4, MispredCnt4}),
            64'({4'(sat4(n)), 4'(sat4(n))}));
      next_cycle();
      drive(1'b0, NOP, 1'b0, 1'b1);
      #2;
      check($sformatf("sat%0d redirect", n), 64'({RedirectE, RedirectSelE, FlushD, FlushE}),
            64'(4'b1011));
      next_cycle();
    end
    drive(1'b0, NOP, 1'b0, 1'b0);
    #2;
    check("sat final cnt4", 64'({BranchCnt4, MispredCnt4}), 64'(8'hFF));
    check("sat final cnt32", {BranchCnt, MispredCnt}, {32'd20, 32'd20});
    next_cycle();

    // Mid-stream reset with a full pipe and a mispredicting beq in EX.
    drive(1'b0, ADDI, 1'b0, 1'b0);
    next_cycle();
    drive(1'b0, LW, 1'b0, 1'b0);
    next_cycle();
    drive(1'b0, BEQ0, 1'b0, 1'b0);
    next_cycle();
    drive(1'b1, SUB, 1'b1, 1'b1);
    #2;
    check("rst hold redirect", 64'({RedirectE, FlushD, FlushE, RedirectE4, FlushE4}), 64'(5'b0));
    next_cycle();
    drive(1'b0, NOP, 1'b0, 1'b0);
    #2;
    check("rst ctl", 64'(act_ctl()), 64'(13'b0));
    check("rst cnt32", {BranchCnt, MispredCnt}, 64'(0));
    check("rst cnt4", 64'({BranchCnt4, MispredCnt4}), 64'(0));

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/ctrl_pipe.md
Name: ctrl_pipe

Overview:
- Consumer end of the decoded-control interface: captures the ID-stage control bundle and carries it through the ID/EX, EX/MEM and MEM/WB pipeline registers.
- Resolves branches and jumps in EX against the static prediction made at fetch. Drives the PC redirect and the IF/ID and ID/EX flushes.
- Keeps saturating branch and mispredict performance counters.
- Sits between the instruction decoder, hazard unit, ALU zero flag and the PC-select logic.

Parameters:
- CNT_W, 32, width of the branch and mispredict performance counters.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- ValidD  in  1  ID stage holds a real instruction.
- RegWriteD  in  1  decoded register write enable.
- ResultSrcD  in  2  decoded result select: 00 ALU, 01 memory, 10 PC+4.
- MemWriteD  in  1  decoded memory write enable.
- JumpD  in  1  decoded jump.
- BranchD  in  1  decoded conditional branch.
- ALUSrcD  in  1  decoded ALU source select.
- ALUControlD  in  3  decoded ALU operation.
- funct3b0D  in  1  funct3[0]; 0 = beq, 1 = bne.
- PredTakenD  in  1  static prediction made at fetch for this instruction.
- FlushEExt  in  1  hazard-unit bubble request for ID/EX (load-use).
- ZeroE  in  1  ALU zero flag for the EX instruction.
- ALUSrcE, ALUControlE  out  1, 3  EX-stage control.
- MemWriteM  out  1  MEM-stage write enable.
- RegWriteM  out  1  MEM-stage write enable, for forwarding.
- ResultSrcW  out  2  WB-stage result select.
- RegWriteW  out  1  WB-stage write enable.
- RedirectE  out  1  EX-resolved misprediction; PC must be redirected.
- RedirectSelE  out  1  0 = branch/jump target, 1 = branch PC+4.
- FlushD  out  1  flush IF/ID.
- FlushE  out  1  flush ID/EX, combinational to the hazard path.
- BranchCnt  out  CNT_W  count of resolved branches and jumps.
- MispredCnt  out  CNT_W  count of mispredictions.

Behaviour:
- Registers, each advanced every cycle (no stall input):
  - ID/EX: Valid, RegWrite, ResultSrc, MemWrite, Jump, Branch, ALUSrc, ALUControl, funct3b0, PredTaken.
  - EX/MEM: Valid, RegWrite, ResultSrc, MemWrite.
  - MEM/WB: Valid, RegWrite, ResultSrc.
- Latency: ID to EX 1 cycle, to MEM 2 cycles, to WB 3 cycles.
- Reset: every register, both counters and every output go to 0 on the first rising edge with reset high. RedirectE, FlushD and FlushE are also 0 while reset is asserted.
- Resolution in EX, combinational:
  - TakenE = ValidE & (JumpE | (BranchE & (ZeroE ^ funct3b0E))).
  - RedirectE = ValidE & (JumpE | BranchE) & (TakenE != PredTakenE).
  - RedirectSelE = PredTakenE & ~TakenE.
- FlushD = RedirectE.
- FlushE = RedirectE | FlushEExt.
- Bubble rule: when FlushE is high, the ID/EX register loads all zeros, including Valid and PredTaken. The EX/MEM load that cycle is unaffected; the resolving branch itself continues down the pipe.
- Bubble or invalid instruction in EX: never redirects and never counts, regardless of ZeroE, Branch or PredTaken.
- Counters:
  - BranchCnt increments when ValidE & (BranchE | JumpE).
  - MispredCnt increments when RedirectE.
  - Both saturate at all-ones; no wrap.
- Simultaneous FlushEExt and RedirectE: a single bubble is inserted and the redirect proceeds normally.
- ValidD = 0: the ID/EX register loads zeros, same as a flush.
- Reset mid-operation: all in-flight control is discarded. No RedirectE or counter change on the reset edge.

Test Plan:
- Reset → ALU add with RegWriteD=1, ResultSrcD=00 held 1 cycle → ALUControlE valid at +1, RegWriteM=1 at +2, RegWriteW=1 and ResultSrcW=00 at +3; RedirectE=0 throughout.
- beq, PredTakenD=0, ZeroE=1 → RedirectE=1, RedirectSelE=0, FlushD=FlushE=1; next cycle ID/EX Valid=0; BranchCnt=1, MispredCnt=1.
- bne (funct3b0D=1), PredTakenD=1, ZeroE=1 → not taken: RedirectE=1, RedirectSelE=1. Repeat with ZeroE=0 → RedirectE=0; MispredCnt unchanged.
- Jump with PredTakenD=0 → RedirectE=1, RedirectSelE=0. Jump with PredTakenD=1 → no redirect; BranchCnt +1 in both cases.
- FlushEExt=1 in the same cycle as a mispredicting branch in EX → one bubble, RedirectE=1, counters each +1. FlushEExt alone over a branch in ID → that branch never resolves and counters do not change.
- Preload counters near all-ones with CNT_W=4 and 20 mispredicting branches → both counters hold 4'hF; assert reset mid-stream → all outputs 0 next cycle.
